rr_lock_arbiter: RTL and testbench



---
 rtl/rr_lock_arbiter.sv | 141 ++++++++++++++
 tb/tb_rr_lock_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: round-robin lock arbiter for one shared resource.
// The owner keeps the grant while it holds its request. Once it has held the
// grant for MAX_HOLD cycles, it is preempted if any other requester is waiting.
// Every change of owner is separated by a one-cycle TURN and a fresh IDLE
// arbitration. The previous owner gets the lowest priority in that arbitration.
module rr_lock_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id,
  output logic               preempt,
  output logic [CNT_W-1:0]   hold_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_TURN  = 2'd2;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

  logic [1:0]         state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic               preempt_q, preempt_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

  logic               sel_found;
  logic [ID_W-1:0]    sel_id;
  logic [ID_W-1:0]    scan_idx;
  logic               own_req;
  logic               others_req;
  logic               hold_sat;

  // Cyclic priority scan: first set request at or after ptr, wrapping at NUM_REQ-1.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    scan_idx  = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!sel_found && req[scan_idx]) begin
        sel_found = 1'b1;
        sel_id    = scan_idx;
      end
      scan_idx = (scan_idx == LAST_ID) ? '0 : scan_idx + 1'b1;
    end
  end

  // Owner status: whether it still requests, and whether anyone else is waiting.
  always_comb begin
    own_req    = req[gnt_id_q];
    others_req = |(req & ~(NUM_REQ'(1) << gnt_id_q));
    hold_sat   = (hold_cnt_q == HOLD_MAX);
  end

  // Next-state logic for the IDLE -> GRANT -> TURN cycle.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    preempt_d   = 1'b0;   // preempt is a single-cycle pulse, live only during TURN
    hold_cnt_d  = hold_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          gnt_d       = NUM_REQ'(1) << sel_id;
          gnt_valid_d = 1'b1;
          gnt_id_d    = sel_id;
          hold_cnt_d  = CNT_W'(1);
          state_d     = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!own_req) begin
          // A voluntary release wins over expiry in the same cycle.
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          state_d     = S_TURN;
        end else if (hold_sat && others_req) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          preempt_d   = 1'b1;
          state_d     = S_TURN;
        end else if (!hold_sat) begin
          hold_cnt_d  = hold_cnt_q + 1'b1;
        end
      end
      S_TURN: begin
        // The previous owner moves to the lowest priority. gnt_id keeps the previous owner for observers.
        ptr_d      = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + 1'b1;
        hold_cnt_d = '0;
        state_d    = S_IDLE;
      end
      default: begin
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = '0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State registers. Reset wins over any arbitration in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      preempt_q   <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      preempt_q   <= preempt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign preempt   = preempt_q;
  assign hold_cnt  = hold_cnt_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter with NUM_REQ=4 and MAX_HOLD=8.
module tb_rr_lock_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req   = 4'b0000;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       preempt;
  logic [3:0] hold_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  rr_lock_arbiter #(.NUM_REQ(4), .ID_W(2), .MAX_HOLD(8), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .req(req), .gnt(gnt), .gnt_valid(gnt_valid),
    .gnt_id(gnt_id), .preempt(preempt), .hold_cnt(hold_cnt)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    tick();
    tick();
    tests++;
    if ({gnt, gnt_valid, gnt_id, preempt, hold_cnt} !== 12'd0) begin
      fails++;
      $display("FAIL reset_outputs: got gnt=%b v=%b id=%0d pre=%b hold=%0d want all zero",
               gnt, gnt_valid, gnt_id, preempt, hold_cnt);
    end
    reset = 1'b0;
    req   = 4'b0000;
    tick();
    tests++;
    if ({gnt, gnt_valid} !== 5'd0) begin
      fails++;
      $display("FAIL idle_no_req: got gnt=%b v=%b want 0000 0", gnt, gnt_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    for (int k = 1; k <= 12; k++) begin
      logic [3:0] eh;
      eh = (k > 8) ? 4'd8 : 4'(k);
      tick();
      tests++;
      if ({gnt, gnt_valid, gnt_id, preempt, hold_cnt} !== {4'b0100, 1'b1, 2'd2, 1'b0, eh}) begin
        fails++;
        $display("FAIL single_hold c%0d: got gnt=%b v=%b id=%0d pre=%b hold=%0d want 0100 1 2 0 %0d",
                 k, gnt, gnt_valid, gnt_id, preempt, hold_cnt, eh);
      end
    end
    req = 4'b0000;
    tick();
    tests++;
    if ({gnt, gnt_valid, gnt_id, preempt} !== {4'b0000, 1'b0, 2'd2, 1'b0}) begin
      fails++;
      $display("FAIL single_release: got gnt=%b v=%b id=%0d pre=%b want 0000 0 2 0",
               gnt, gnt_valid, gnt_id, preempt);
    end
  endtask

  task automatic test_alternate();
    do_reset();
    req = 4'b0011;
    for (int r = 0; r < 3; r++) begin
      logic [1:0] eo;
      logic [3:0] eg;
      eo = 2'(r % 2);
      eg = 4'b0001 << eo;
      for (int k = 1; k <= 8; k++) begin
        tick();
        tests++;
        if ({gnt, gnt_valid, gnt_id, preempt, hold_cnt} !== {eg, 1'b1, eo, 1'b0, 4'(k)}) begin
          fails++;
          $display("FAIL alt_grant r%0d c%0d: got gnt=%b id=%0d pre=%b hold=%0d want %b %0d 0 %0d",
                   r, k, gnt, gnt_id, preempt, hold_cnt, eg, eo, k);
        end
      end
      tick();
      tests++;
      if ({gnt, gnt_valid, preempt, gnt_id} !== {4'b0000, 1'b0, 1'b1, eo}) begin
        fails++;
        $display("FAIL alt_preempt r%0d: got gnt=%b v=%b pre=%b id=%0d want 0000 0 1 %0d",
                 r, gnt, gnt_valid, preempt, gnt_id, eo);
      end
      tick();
      tests++;
      if ({gnt, gnt_valid, preempt} !== 6'd0) begin
        fails++;
        $display("FAIL alt_gap r%0d: got gnt=%b v=%b pre=%b want 0000 0 0", r, gnt, gnt_valid, preempt);
      end
    end
  endtask

  task automatic test_release();
    do_reset();
    req = 4'b1001;
    for (int k = 1; k <= 3; k++) begin
      tick();
      tests++;
      if ({gnt, hold_cnt} !== {4'b0001, 4'(k)}) begin
        fails++;
        $display("FAIL rel_hold c%0d: got gnt=%b hold=%0d want 0001 %0d", k, gnt, hold_cnt, k);
      end
    end
    req = 4'b1000;
    for (int k = 0; k < 2; k++) begin
      tick();
      tests++;
      if ({gnt, gnt_valid, preempt} !== 6'd0) begin
        fails++;
        $display("FAIL rel_gap c%0d: got gnt=%b v=%b pre=%b want 0000 0 0", k, gnt, gnt_valid, preempt);
      end
    end
    tick();
    tests++;
    if ({gnt, gnt_valid, gnt_id, preempt, hold_cnt} !== {4'b1000, 1'b1, 2'd3, 1'b0, 4'd1}) begin
      fails++;
      $display("FAIL rel_next: got gnt=%b v=%b id=%0d pre=%b hold=%0d want 1000 1 3 0 1",
               gnt, gnt_valid, gnt_id, preempt, hold_cnt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      logic [1:0] eo;
      logic [3:0] eg;
      eo = 2'(r % 4);
      eg = 4'b0001 << eo;
      tick();
      tests++;
      if ({gnt, gnt_id, hold_cnt} !== {eg, eo, 4'd1}) begin
        fails++;
        $display("FAIL wrap_first r%0d: got gnt=%b id=%0d hold=%0d want %b %0d 1",
                 r, gnt, gnt_id, hold_cnt, eg, eo);
      end
      for (int k = 2; k <= 8; k++) tick();
      tests++;
      if ({gnt, hold_cnt, preempt} !== {eg, 4'd8, 1'b0}) begin
        fails++;
        $display("FAIL wrap_last r%0d: got gnt=%b hold=%0d pre=%b want %b 8 0", r, gnt, hold_cnt, preempt, eg);
      end
      tick();
      tests++;
      if ({gnt, preempt} !== {4'b0000, 1'b1}) begin
        fails++;
        $display("FAIL wrap_preempt r%0d: got gnt=%b pre=%b want 0000 1", r, gnt, preempt);
      end
      tick();
    end
  endtask

  task automatic test_release_at_max();
    do_reset();
    req = 4'b0001;
    for (int k = 1; k <= 10; k++) tick();
    tests++;
    if ({gnt, hold_cnt, preempt} !== {4'b0001, 4'd8, 1'b0}) begin
      fails++;
      $display("FAIL sat_hold: got gnt=%b hold=%0d pre=%b want 0001 8 0", gnt, hold_cnt, preempt);
    end
    req = 4'b0100;
    tick();
    tests++;
    if ({gnt, gnt_valid, preempt} !== 6'd0) begin
      fails++;
      $display("FAIL max_release: got gnt=%b v=%b pre=%b want 0000 0 0", gnt, gnt_valid, preempt);
    end
    tick();
    tick();
    tests++;
    if ({gnt, gnt_id} !== {4'b0100, 2'd2}) begin
      fails++;
      $display("FAIL max_next: got gnt=%b id=%0d want 0100 2", gnt, gnt_id);
    end
  endtask

  task automatic test_sat_preempt();
    do_reset();
    req = 4'b0010;
    for (int k = 1; k <= 11; k++) tick();
    req = 4'b0011;
    tick();
    tests++;
    if ({gnt, gnt_valid, preempt, gnt_id} !== {4'b0000, 1'b0, 1'b1, 2'd1}) begin
      fails++;
      $display("FAIL sat_preempt: got gnt=%b v=%b pre=%b id=%0d want 0000 0 1 1",
               gnt, gnt_valid, preempt, gnt_id);
    end
    tick();
    tick();
    tests++;
    if (gnt !== 4'b0001) begin
      fails++;
      $display("FAIL sat_next: got gnt=%b want 0001", gnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    tick();
    req = 4'b0110;
    for (int k = 0; k < 3; k++) tick();
    tests++;
    if ({gnt, hold_cnt} !== {4'b0010, 4'd3}) begin
      fails++;
      $display("FAIL mid_pre: got gnt=%b hold=%0d want 0010 3", gnt, hold_cnt);
    end
    reset = 1'b1;
    tick();
    tests++;
    if ({gnt, gnt_valid, gnt_id, preempt, hold_cnt} !== 12'd0) begin
      fails++;
      $display("FAIL mid_reset: got gnt=%b v=%b id=%0d pre=%b hold=%0d want all zero",
               gnt, gnt_valid, gnt_id, preempt, hold_cnt);
    end
    reset = 1'b0;
    tick();
    tests++;
    if ({gnt, gnt_id, hold_cnt} !== {4'b0010, 2'd1, 4'd1}) begin
      fails++;
      $display("FAIL mid_regrant: got gnt=%b id=%0d hold=%0d want 0010 1 1", gnt, gnt_id, hold_cnt);
    end
    // Move ptr to 2, then reset: a stale pointer would pick requester 2 over 0.
    req = 4'b0000;
    tick();
    tick();
    reset = 1'b1;
    req   = 4'b0101;
    tick();
    tests++;
    if ({gnt, gnt_valid} !== 5'd0) begin
      fails++;
      $display("FAIL reset_no_grant: got gnt=%b v=%b want 0000 0", gnt, gnt_valid);
    end
    reset = 1'b0;
    tick();
    tests++;
    if ({gnt, gnt_id} !== {4'b0001, 2'd0}) begin
      fails++;
      $display("FAIL ptr_reset: got gnt=%b id=%0d want 0001 0", gnt, gnt_id);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_release();
    test_wrap();
    test_release_at_max();
    test_sat_preempt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
